// File: rtl/mult_pkg.sv
// Shared constants and state type for the sequential multiplier (and the divider's width).
package mult_pkg;

  localparam int unsigned MULT_W     = 32;
  localparam int unsigned MULT_STEPS = 32;
  localparam int unsigned CNT_W      = $clog2(MULT_STEPS);
  localparam int unsigned M_W        = MULT_W + 1;
  localparam int unsigned P_W        = 2 * MULT_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into the upper 33 bits of P,
// then arithmetic shift right of the whole 66-bit P.
module booth_step
  import mult_pkg::*;
(
  input  logic [P_W-1:0] p,
  input  logic [M_W-1:0] m,
  output logic [P_W-1:0] p_next
);

  logic [M_W-1:0] acc;
  logic [M_W-1:0] sum;

  assign acc = p[P_W-1:MULT_W+1];

  always_comb begin
    sum = acc;
    unique case (p[1:0])
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  assign p_next = {sum[M_W-1], sum, p[MULT_W:1]};

endmodule

// File: rtl/mult.sv
// Sequential signed 32x32 Booth multiplier with start/done handshake.
// Optional build macro MULT_ZERO_SKIP_EN finishes zero-operand requests in one cycle.
module mult
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MULT_W-1:0] A,
  input  logic [MULT_W-1:0] B,
  output logic [MULT_W-1:0] hi,
  output logic [MULT_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  state_t             state_q, state_d;
  logic [P_W-1:0]     p_q, p_d;
  logic [M_W-1:0]     m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MULT_W-1:0]  hi_q, hi_d;
  logic [MULT_W-1:0]  lo_q, lo_d;
  logic [P_W-1:0]     p_step;

  booth_step u_booth_step (
    .p      (p_q),
    .m      (m_q),
    .p_next (p_step)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULT_ZERO_SKIP_EN
          if ((A == '0) || (B == '0)) begin
            state_d = DONE;
            hi_d    = '0;
            lo_d    = '0;
          end else begin
            state_d = RUN;
            m_d     = {A[MULT_W-1], A};
            p_d     = {{M_W{1'b0}}, B, 1'b0};
            cnt_d   = '0;
          end
`else
          state_d = RUN;
          m_d     = {A[MULT_W-1], A};
          p_d     = {{M_W{1'b0}}, B, 1'b0};
          cnt_d   = '0;
`endif
        end
      end
      RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MULT_STEPS - 1)) begin
          state_d      = DONE;
          {hi_d, lo_d} = p_step[2*MULT_W:1];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status decodes straight from state so an async reset clears them without a clock.
  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: latency/product model plus hand-computed vectors.
module tb_mult;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  mult dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request leaves the unit busy for 33 cycles (1 with zero skip);
  // the product appears with done, in the last busy cycle.
  int          mdl_cnt = 0;
  logic [63:0] mdl_prod = '0;
  logic [63:0] mdl_pend = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_cnt  = 0;
      mdl_prod = '0;
    end else if (mdl_cnt == 0) begin
      if (start) begin
        mdl_pend = 64'(longint'($signed(A)) * longint'($signed(B)));
`ifdef MULT_ZERO_SKIP_EN
        if (A == 0 || B == 0) begin
          mdl_prod = '0;
          mdl_cnt  = 1;
        end else begin
          mdl_cnt = 33;
        end
`else
        mdl_cnt = 33;
`endif
      end
    end else begin
      mdl_cnt--;
      if (mdl_cnt == 1) mdl_prod = mdl_pend;
    end
  end

  always @(negedge clk) begin
    check("cyc_hi", hi, mdl_prod[63:32]);
    check("cyc_lo", lo, mdl_prod[31:0]);
    check("cyc_busy", {31'b0, busy}, {31'b0, mdl_cnt != 0});
    check("cyc_done", {31'b0, done}, {31'b0, mdl_cnt == 1});
  end

  // Returns k = number of edges after E0 at which done was first seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                        output int k);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 32'hDEAD_BEEF;
    B = 32'h1357_9BDF;
    start = hold;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
  endtask

  int k;
  int ndone;
  int exp_zero_k;

  initial begin
`ifdef MULT_ZERO_SKIP_EN
    exp_zero_k = 0;
`else
    exp_zero_k = 32;
`endif
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, k);
    check("7x6_lat", k, 32);
    check("7x6_hi", hi, 32'h0000_0000);
    check("7x6_lo", lo, 32'h0000_002A);
    @(negedge clk);
    check("7x6_busy_after", {31'b0, busy}, 32'h0);

    run_op(32'hFFFF_FFFD, 32'd5, 1'b0, k);
    check("m3x5_lat", k, 32);
    check("m3x5_hi", hi, 32'hFFFF_FFFF);
    check("m3x5_lo", lo, 32'hFFFF_FFF1);

    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, k);
    check("min_hi", hi, 32'h4000_0000);
    check("min_lo", lo, 32'h0000_0000);

    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, k);
    check("max_lat", k, 32);
    check("max_hi", hi, 32'h3FFF_FFFF);
    check("max_lo", lo, 32'h0000_0001);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("max_extra_done", ndone, 0);
    check("max_hi_hold", hi, 32'h3FFF_FFFF);
    check("max_lo_hold", lo, 32'h0000_0001);

    // Abort mid-run with an asynchronous reset between edges.
    @(negedge clk);
    A = 32'd9;
    B = 32'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;

    run_op(32'd3, 32'd4, 1'b0, k);
    check("3x4_lat", k, 32);
    check("3x4_hi", hi, 32'h0);
    check("3x4_lo", lo, 32'd12);

    // Non-zero result first so a zero product is observable.
    run_op(32'd5, 32'd5, 1'b0, k);
    check("5x5_lo", lo, 32'd25);
    run_op(32'h0, 32'h1234_5678, 1'b0, k);
    check("zero_lat", k, exp_zero_k);
    check("zero_hi", hi, 32'h0);
    check("zero_lo", lo, 32'h0);
    @(negedge clk);
    check("zero_busy_after", {31'b0, busy}, 32'h0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
